// File: rtl/mpsoc_ahb3_spram_master.sv
// AHB3-Lite single-transfer master: turns a command/response handshake into pipelined
// NONSEQ transfers, honouring wait states and the two-cycle ERROR response.
module mpsoc_ahb3_spram_master #(
    parameter int HADDR_SIZE = 64,
    parameter int HDATA_SIZE = 64
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic                  cmd_req,
    output logic                  cmd_ack,
    input  logic                  cmd_we,
    input  logic [HADDR_SIZE-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [HDATA_SIZE-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [HDATA_SIZE-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    typedef enum logic {RUN, ERR} state_t;

    state_t                  state;
    logic                    ap_valid;
    logic                    ap_we;
    logic [HDATA_SIZE-1:0]   ap_wdata;
    logic                    dp_valid;
    logic                    dp_we;
    logic                    ap_adv;
    logic                    dp_done;

    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    // HADDR/HWRITE/HSIZE double as the address-phase register's addr/we/size fields
    assign cmd_ack = HRESETn & cmd_req & (state == RUN) & (~ap_valid | HREADY);
    // In ERR the bus shows IDLE, so a held command has not had an address phase yet
    assign ap_adv  = (state == RUN) & ap_valid & HREADY;
    assign dp_done = dp_valid & HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= RUN;
            ap_valid  <= 1'b0;
            ap_we     <= 1'b0;
            ap_wdata  <= '0;
            dp_valid  <= 1'b0;
            dp_we     <= 1'b0;
            HSEL      <= 1'b0;
            HTRANS    <= IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'b000;
            HWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (cmd_ack) begin
                ap_valid <= 1'b1;
                ap_we    <= cmd_we;
                ap_wdata <= cmd_wdata;
                HADDR    <= cmd_addr;
                HWRITE   <= cmd_we;
                HSIZE    <= cmd_size;
            end else if (ap_adv) begin
                ap_valid <= 1'b0;
            end

            if (ap_adv) begin
                dp_valid <= 1'b1;
                dp_we    <= ap_we;
                if (ap_we) HWDATA <= ap_wdata;
            end else if (dp_done) begin
                dp_valid <= 1'b0;
            end

            rsp_valid <= dp_done;
            rsp_err   <= dp_done & HRESP;
            rsp_rdata <= (dp_done & ~dp_we) ? HRDATA : '0;

            case (state)
                RUN: begin
                    if (dp_valid & HRESP & ~HREADY) begin
                        state  <= ERR;
                        HTRANS <= IDLE;
                        HSEL   <= 1'b0;
                    end else if (cmd_ack) begin
                        HTRANS <= NONSEQ;
                        HSEL   <= 1'b1;
                    end else if (ap_adv) begin
                        HTRANS <= IDLE;
                        HSEL   <= 1'b0;
                    end
                end
                ERR: begin
                    if (HREADY) begin
                        state <= RUN;
                        if (ap_valid) begin
                            HTRANS <= NONSEQ;
                            HSEL   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpsoc_ahb3_spram_master.sv
// Directed bench for mpsoc_ahb3_spram_master with a small AHB3-Lite SPRAM slave model
// that can inject wait states and a two-cycle ERROR response on chosen addresses.
module tb_mpsoc_ahb3_spram_master;

    localparam logic [63:0] NOADDR = 64'hFFFF_FFFF_FFFF_FFF0;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_req, cmd_ack, cmd_we;
    logic [63:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [63:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int tests = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    mpsoc_ahb3_spram_master #(.HADDR_SIZE(64), .HDATA_SIZE(64)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // Slave model: memory indexed by doubleword, optional waits / ERROR by address
    logic [63:0] mem [0:63];
    logic        s_act, s_we, s_err, s_errc;
    logic [63:0] s_addr;
    int          s_wait;
    logic [63:0] wait_addr = NOADDR;
    logic [63:0] err_addr  = NOADDR;
    int          wait_n    = 0;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (s_act) begin
            if (s_err) begin
                HRESP  = 1'b1;
                HREADY = s_errc;
            end else if (s_wait != 0) begin
                HREADY = 1'b0;
            end
            if (!s_we) HRDATA = mem[s_addr[8:3]];
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_act <= 1'b0; s_we <= 1'b0; s_err <= 1'b0; s_errc <= 1'b0;
            s_wait <= 0; s_addr <= '0;
        end else begin
            if (s_act) begin
                if (s_err) s_errc <= 1'b1;
                else if (s_wait != 0) s_wait <= s_wait - 1;
                else if (s_we) mem[s_addr[8:3]] <= HWDATA;
            end
            if (HREADY) begin
                s_act  <= HSEL && (HTRANS == 2'b10);
                s_we   <= HWRITE;
                s_addr <= HADDR;
                s_wait <= (HADDR == wait_addr) ? wait_n : 0;
                s_err  <= (HADDR == err_addr);
                s_errc <= 1'b0;
            end
        end
    end

    // Per-cycle bus log and response log, sampled on the falling edge
    int          cyc = 0;
    logic [1:0]  trans_log [0:4095];
    logic [63:0] addr_log  [0:4095];
    logic        ack_log   [0:4095];
    logic [63:0] rsp_d [0:255];
    logic        rsp_e [0:255];
    int          rsp_c [0:255];
    int          rsp_n = 0;

    function automatic logic [11:0] ix(input int v);
        return 12'(v);
    endfunction

    function automatic logic [63:0] wdat(input int i);
        return 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h0101_0101_0101_0101;
    endfunction

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        trans_log[ix(cyc)] = HTRANS;
        addr_log[ix(cyc)]  = HADDR;
        ack_log[ix(cyc)]   = cmd_ack;
        if (rsp_valid) begin
            rsp_d[rsp_n[7:0]] = rsp_rdata;
            rsp_e[rsp_n[7:0]] = rsp_err;
            rsp_c[rsp_n[7:0]] = cyc;
            rsp_n = rsp_n + 1;
        end
    end

    task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                         output int acc);
        acc = -1;
        cmd_req = 1'b1; cmd_we = we; cmd_addr = addr; cmd_size = 3'd3; cmd_wdata = wd;
        for (int i = 0; i < 40; i++) begin
            @(negedge HCLK);
            if (cmd_ack) begin
                acc = cyc;
                @(posedge HCLK); #1;
                cmd_req = 1'b0;
                return;
            end
            @(posedge HCLK); #1;
        end
        cmd_req = 1'b0;
        tests++; fails++;
        $display("FAIL issue_timeout addr=%h: cmd_ack never seen, required within 40 cycles", addr);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 60 && rsp_n < target; i++) @(posedge HCLK);
        repeat (3) @(posedge HCLK);
        #1;
        tests++;
        if (rsp_n !== target) begin
            fails++;
            $display("FAIL rsp_count: got %0d responses, required %0d", rsp_n, target);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        cmd_req = 1'b1; cmd_we = 1'b1; cmd_addr = 64'h40; cmd_size = 3'd3; cmd_wdata = '1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        tests++; if (HSEL !== 1'b0) begin fails++; $display("FAIL rst_hsel: got %b required 0", HSEL); end
        tests++; if (HTRANS !== 2'b00) begin fails++; $display("FAIL rst_htrans: got %b required 00", HTRANS); end
        tests++; if (HADDR !== 64'h0) begin fails++; $display("FAIL rst_haddr: got %h required 0", HADDR); end
        tests++; if (HWDATA !== 64'h0) begin fails++; $display("FAIL rst_hwdata: got %h required 0", HWDATA); end
        tests++; if ({HWRITE, HSIZE, HBURST, HMASTLOCK} !== 8'h00) begin fails++;
            $display("FAIL rst_ctrl: got hwrite=%b hsize=%h hburst=%h hmastlock=%b required all 0", HWRITE, HSIZE, HBURST, HMASTLOCK); end
        tests++; if (HPROT !== 4'b0011) begin fails++; $display("FAIL rst_hprot: got %b required 0011", HPROT); end
        tests++; if (cmd_ack !== 1'b0) begin fails++; $display("FAIL rst_cmd_ack: got %b required 0", cmd_ack); end
        tests++; if ({rsp_valid, rsp_err} !== 2'b00 || rsp_rdata !== 64'h0) begin fails++;
            $display("FAIL rst_rsp: got valid=%b err=%b rdata=%h required 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        cmd_req = 1'b0;
        repeat (2) @(posedge HCLK); #1;
    endtask

    task automatic test_single_write_read();
        int base, aw, ar;
        base = rsp_n;
        issue(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, aw);
        wait_rsp(base + 1);
        issue(1'b0, 64'h10, 64'h0, ar);
        wait_rsp(base + 2);
        tests++; if (trans_log[ix(aw+1)] !== 2'b10 || addr_log[ix(aw+1)] !== 64'h10) begin fails++;
            $display("FAIL single_wr_aphase: got htrans=%b haddr=%h required 10/0x10", trans_log[ix(aw+1)], addr_log[ix(aw+1)]); end
        tests++; if (trans_log[ix(aw+2)] !== 2'b00) begin fails++;
            $display("FAIL single_wr_idle: got htrans=%b required 00", trans_log[ix(aw+2)]); end
        tests++; if (trans_log[ix(ar+1)] !== 2'b10 || trans_log[ix(ar+2)] !== 2'b00) begin fails++;
            $display("FAIL single_rd_nonseq_1cyc: got %b,%b required 10,00", trans_log[ix(ar+1)], trans_log[ix(ar+2)]); end
        tests++; if (rsp_c[base] !== aw + 3) begin fails++;
            $display("FAIL single_wr_latency: got cycle %0d required %0d", rsp_c[base], aw + 3); end
        tests++; if (rsp_d[base] !== 64'h0 || rsp_e[base] !== 1'b0) begin fails++;
            $display("FAIL single_wr_rsp: got rdata=%h err=%b required 0/0", rsp_d[base], rsp_e[base]); end
        tests++; if (rsp_c[base+1] !== ar + 3) begin fails++;
            $display("FAIL single_rd_latency: got cycle %0d required %0d", rsp_c[base+1], ar + 3); end
        tests++; if (rsp_d[base+1] !== 64'hDEADBEEF_CAFEF00D || rsp_e[base+1] !== 1'b0) begin fails++;
            $display("FAIL single_rd_rsp: got rdata=%h err=%b required deadbeefcafef00d/0", rsp_d[base+1], rsp_e[base+1]); end
    endtask

    task automatic test_back_to_back();
        int base, nonseq;
        int acc [16];
        base = rsp_n;
        for (int i = 0; i < 8; i++) issue(1'b1, 64'(i * 8), wdat(i), acc[i]);
        for (int i = 0; i < 8; i++) issue(1'b0, 64'(i * 8), 64'h0, acc[8+i]);
        wait_rsp(base + 16);
        nonseq = 0;
        for (int k = 1; k <= 16; k++) if (trans_log[ix(acc[0]+k)] === 2'b10) nonseq++;
        tests++; if (nonseq !== 16) begin fails++;
            $display("FAIL b2b_nonseq_run: got %0d NONSEQ cycles required 16", nonseq); end
        tests++; if (trans_log[ix(acc[0]+17)] !== 2'b00) begin fails++;
            $display("FAIL b2b_idle_after: got htrans=%b required 00", trans_log[ix(acc[0]+17)]); end
        for (int i = 0; i < 16; i++) begin
            tests++; if (addr_log[ix(acc[0]+1+i)] !== 64'((i % 8) * 8)) begin fails++;
                $display("FAIL b2b_haddr[%0d]: got %h required %h", i, addr_log[ix(acc[0]+1+i)], 64'((i % 8) * 8)); end
            tests++; if (rsp_c[base+i] !== acc[0] + 3 + i) begin fails++;
                $display("FAIL b2b_rsp_cycle[%0d]: got %0d required %0d", i, rsp_c[base+i], acc[0] + 3 + i); end
            tests++; if (rsp_d[base+i] !== ((i < 8) ? 64'h0 : wdat(i - 8)) || rsp_e[base+i] !== 1'b0) begin fails++;
                $display("FAIL b2b_rsp[%0d]: got rdata=%h err=%b required %h/0", i, rsp_d[base+i], rsp_e[base+i], (i < 8) ? 64'h0 : wdat(i - 8)); end
        end
    endtask

    task automatic test_wait_states();
        int base, a;
        int acc [4];
        logic [63:0] exp_d [4];
        exp_d[0] = 64'h4040_0000_0000_0040; exp_d[1] = 64'h4848_0000_0000_0048;
        exp_d[2] = 64'h5050_0000_0000_0050; exp_d[3] = 64'h5858_0000_0000_0058;
        base = rsp_n;
        for (int i = 0; i < 4; i++) issue(1'b1, 64'(64 + i * 8), exp_d[i], acc[i]);
        wait_rsp(base + 4);
        wait_addr = 64'h48; wait_n = 2;
        base = rsp_n;
        for (int i = 0; i < 4; i++) issue(1'b0, 64'(64 + i * 8), 64'h0, acc[i]);
        wait_rsp(base + 4);
        wait_addr = NOADDR;
        a = acc[0];
        tests++; if (acc[1] !== a + 1 || acc[2] !== a + 2 || acc[3] !== a + 5) begin fails++;
            $display("FAIL wait_accept_cycles: got +%0d,+%0d,+%0d required +1,+2,+5", acc[1]-a, acc[2]-a, acc[3]-a); end
        tests++; if (ack_log[ix(a+3)] !== 1'b0 || ack_log[ix(a+4)] !== 1'b0) begin fails++;
            $display("FAIL wait_cmd_ack_low: got %b,%b required 0,0", ack_log[ix(a+3)], ack_log[ix(a+4)]); end
        for (int k = 3; k <= 5; k++) begin
            tests++; if (trans_log[ix(a+k)] !== 2'b10 || addr_log[ix(a+k)] !== 64'h50) begin fails++;
                $display("FAIL wait_hold_3rd[%0d]: got htrans=%b haddr=%h required 10/0x50", k, trans_log[ix(a+k)], addr_log[ix(a+k)]); end
        end
        for (int i = 0; i < 4; i++) begin
            tests++; if (rsp_d[base+i] !== exp_d[i] || rsp_e[base+i] !== 1'b0) begin fails++;
                $display("FAIL wait_rsp[%0d]: got rdata=%h err=%b required %h/0", i, rsp_d[base+i], rsp_e[base+i], exp_d[i]); end
        end
        tests++; if (rsp_c[base] !== a + 3 || rsp_c[base+1] !== a + 6 || rsp_c[base+2] !== a + 7 || rsp_c[base+3] !== a + 8) begin fails++;
            $display("FAIL wait_rsp_cycles: got +%0d,+%0d,+%0d,+%0d required +3,+6,+7,+8",
                     rsp_c[base]-a, rsp_c[base+1]-a, rsp_c[base+2]-a, rsp_c[base+3]-a); end
    endtask

    task automatic test_error();
        int base, aw, ar, dummy;
        base = rsp_n;
        issue(1'b1, 64'h108, 64'h1080_1080_1080_1080, dummy);
        wait_rsp(base + 1);
        err_addr = 64'h100;
        base = rsp_n;
        issue(1'b1, 64'h100, 64'h1111_2222_3333_4444, aw);
        issue(1'b0, 64'h108, 64'h0, ar);
        wait_rsp(base + 2);
        err_addr = NOADDR;
        tests++; if (ar !== aw + 1) begin fails++;
            $display("FAIL err_read_accept: got +%0d required +1", ar - aw); end
        tests++; if (trans_log[ix(aw+3)] !== 2'b00) begin fails++;
            $display("FAIL err_idle_2nd_cycle: got htrans=%b required 00", trans_log[ix(aw+3)]); end
        tests++; if (trans_log[ix(aw+4)] !== 2'b10 || addr_log[ix(aw+4)] !== 64'h108) begin fails++;
            $display("FAIL err_reissue: got htrans=%b haddr=%h required 10/0x108", trans_log[ix(aw+4)], addr_log[ix(aw+4)]); end
        tests++; if (rsp_e[base] !== 1'b1 || rsp_c[base] !== aw + 4) begin fails++;
            $display("FAIL err_write_rsp: got err=%b cycle +%0d required 1/+4", rsp_e[base], rsp_c[base] - aw); end
        tests++; if (rsp_e[base+1] !== 1'b0 || rsp_d[base+1] !== 64'h1080_1080_1080_1080 || rsp_c[base+1] !== aw + 6) begin fails++;
            $display("FAIL err_read_rsp: got err=%b rdata=%h cycle +%0d required 0/1080108010801080/+6",
                     rsp_e[base+1], rsp_d[base+1], rsp_c[base+1] - aw); end
    endtask

    task automatic test_reset_midtransfer();
        int base, a1, a2, a3;
        wait_addr = 64'h20; wait_n = 5;
        base = rsp_n;
        issue(1'b0, 64'h20, 64'h0, a1);
        issue(1'b0, 64'h28, 64'h0, a2);
        #2;
        HRESETn = 1'b0;
        cmd_req = 1'b1;
        #1;
        tests++; if (HSEL !== 1'b0 || HTRANS !== 2'b00) begin fails++;
            $display("FAIL midrst_bus: got hsel=%b htrans=%b required 0/00", HSEL, HTRANS); end
        tests++; if (HADDR !== 64'h0 || HWDATA !== 64'h0 || HWRITE !== 1'b0 || HSIZE !== 3'd0) begin fails++;
            $display("FAIL midrst_addr: got haddr=%h hwdata=%h hwrite=%b hsize=%h required 0", HADDR, HWDATA, HWRITE, HSIZE); end
        tests++; if (cmd_ack !== 1'b0 || rsp_valid !== 1'b0) begin fails++;
            $display("FAIL midrst_handshake: got cmd_ack=%b rsp_valid=%b required 0/0", cmd_ack, rsp_valid); end
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cmd_req = 1'b0;
        wait_addr = NOADDR;
        repeat (10) @(posedge HCLK);
        #1;
        tests++; if (rsp_n !== base) begin fails++;
            $display("FAIL midrst_no_rsp: got %0d responses required 0", rsp_n - base); end
        issue(1'b0, 64'h0, 64'h0, a3);
        wait_rsp(base + 1);
        tests++; if (rsp_d[base] !== wdat(0) || rsp_e[base] !== 1'b0 || rsp_c[base] !== a3 + 3) begin fails++;
            $display("FAIL midrst_read_after: got rdata=%h err=%b cycle +%0d required %h/0/+3",
                     rsp_d[base], rsp_e[base], rsp_c[base] - a3, wdat(0)); end
    endtask

    task automatic test_idle();
        cmd_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            tests++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || rsp_valid !== 1'b0) begin fails++;
                $display("FAIL idle[%0d]: got htrans=%b hsel=%b rsp_valid=%b required 00/0/0", i, HTRANS, HSEL, rsp_valid); end
        end
    endtask

    initial begin
        cmd_req = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_size = 3'd0; cmd_wdata = '0;
        test_reset();
        test_single_write_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_midtransfer();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
        $fatal(1);
    end

endmodule
